// File: rtl/gpr_wb_sched_if.sv
// Bundles the write-back source requests, issue/hazard lookups and the single register-file write port.
// Master drives requests and lookups; slave (the scheduler) returns grants, hazards and the write port.
interface gpr_wb_sched_if #(
   parameter int NSRC = 3,
   parameter int XLEN = 32
);
   logic [NSRC-1:0]      src_valid;
   logic [5*NSRC-1:0]    src_rd;
   logic [XLEN*NSRC-1:0] src_data;
   logic [NSRC-1:0]      src_ready;
   logic                 wb_hold;

   logic                 iss_valid;
   logic [4:0]           iss_rd;
   logic [4:0]           gpr_ra;
   logic [4:0]           gpr_rb;
   logic                 hazard_a;
   logic                 hazard_b;

   logic                 gpr_we;
   logic [4:0]           gpr_rd;
   logic [XLEN-1:0]      gpr_di;
   logic                 busy;

   modport master (
      output src_valid, src_rd, src_data, wb_hold,
      output iss_valid, iss_rd, gpr_ra, gpr_rb,
      input  src_ready, hazard_a, hazard_b, gpr_we, gpr_rd, gpr_di, busy
   );

   modport slave (
      input  src_valid, src_rd, src_data, wb_hold,
      input  iss_valid, iss_rd, gpr_ra, gpr_rb,
      output src_ready, hazard_a, hazard_b, gpr_we, gpr_rd, gpr_di, busy
   );
endinterface

// File: rtl/gpr_wb_sched.sv
// Round-robin write-back arbiter for a single-write-port register file plus RAW scoreboard; write lands 1 cycle after grant.
// Sources are held off (src_ready low) while wb_hold is set or another source wins; hazards are combinational from the scoreboard.
module gpr_wb_sched #(
   parameter int NSRC = 3,
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   gpr_wb_sched_if.slave wb
);
   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [PW-1:0]   last_q;
   logic [PW-1:0]   winner;
   logic [NSRC-1:0] grant;
   logic            found;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;

   logic            we_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] di_q;

   logic [31:0]     pend_q;
   logic [31:0]     pend_d;

   function automatic int rr_idx(input logic [PW-1:0] base, input int k);
      return (int'(base) + 1 + k) % NSRC;
   endfunction

   // Search starts one past the previous winner and wraps, so each source waits at most NSRC cycles.
   always_comb begin
      grant  = '0;
      winner = last_q;
      found  = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (!found && wb.src_valid[rr_idx(last_q, k)]) begin
            grant[rr_idx(last_q, k)] = 1'b1;
            winner                   = PW'(rr_idx(last_q, k));
            found                    = 1'b1;
         end
      end
      if (wb.wb_hold || !rst_n) begin
         grant = '0;
         found = 1'b0;
      end
   end

   assign sel_rd   = wb.src_rd[int'(winner)*5 +: 5];
   assign sel_data = wb.src_data[int'(winner)*XLEN +: XLEN];

   // A newer issue to the same register outranks the write that lands on this edge.
   always_comb begin
      pend_d = pend_q;
      if (we_q) begin
         pend_d[rd_q] = 1'b0;
      end
      if (wb.iss_valid && (wb.iss_rd != 5'd0)) begin
         pend_d[wb.iss_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= PW'(NSRC - 1);
         we_q   <= 1'b0;
         rd_q   <= 5'd0;
         di_q   <= '0;
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         we_q   <= found && (sel_rd != 5'd0);
         if (found) begin
            last_q <= winner;
         end
         // x0 grants retire the source but leave the port contents alone.
         if (found && (sel_rd != 5'd0)) begin
            rd_q <= sel_rd;
            di_q <= sel_data;
         end
      end
   end

   // Outputs are gated by rst_n so a write registered just before reset never reaches the file.
   assign wb.src_ready = grant;
   assign wb.gpr_we    = we_q & rst_n;
   assign wb.gpr_rd    = rd_q;
   assign wb.gpr_di    = di_q;
   assign wb.hazard_a  = rst_n & pend_q[wb.gpr_ra];
   assign wb.hazard_b  = rst_n & pend_q[wb.gpr_rb];
   assign wb.busy      = rst_n & ((|pend_q) | we_q);

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(wb.src_ready));
   a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
      ((wb.src_ready & ~wb.src_valid) == '0));
   a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
      wb.gpr_we |-> (wb.gpr_rd != 5'd0));
endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched: arbitration order, write-port timing, scoreboard and reset behaviour.
module tb_gpr_wb_sched;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   gpr_wb_sched_if #(.NSRC(3), .XLEN(32)) wb();

   gpr_wb_sched #(.NSRC(3), .XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb.src_valid[i]        = v;
      wb.src_rd[i*5 +: 5]    = rd;
      wb.src_data[i*32 +: 32] = d;
   endtask

   task automatic idle_inputs;
      wb.src_valid = '0;
      wb.src_rd    = '0;
      wb.src_data  = '0;
      wb.wb_hold   = 1'b0;
      wb.iss_valid = 1'b0;
      wb.iss_rd    = 5'd0;
      wb.gpr_ra    = 5'd0;
      wb.gpr_rb    = 5'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      wb.src_valid = 3'b111;
      #1;
      n_tests++; if (wb.src_ready !== 3'b000) begin n_fail++; $display("FAIL ready_in_reset: got %b expected 000", wb.src_ready); end
      wb.src_valid = 3'b000;
      wb.gpr_ra    = 5'd7;
      wb.gpr_rb    = 5'd31;
      rst_n        = 1'b1;
      tick();
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", wb.gpr_we); end
      n_tests++; if (wb.gpr_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d expected 0", wb.gpr_rd); end
      n_tests++; if (wb.gpr_di !== 32'h0) begin n_fail++; $display("FAIL rst_di: got %h expected 0", wb.gpr_di); end
      n_tests++; if (wb.src_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b expected 000", wb.src_ready); end
      n_tests++; if (wb.hazard_a !== 1'b0) begin n_fail++; $display("FAIL rst_hazard_a: got %b expected 0", wb.hazard_a); end
      n_tests++; if (wb.hazard_b !== 1'b0) begin n_fail++; $display("FAIL rst_hazard_b: got %b expected 0", wb.hazard_b); end
      n_tests++; if (wb.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", wb.busy); end
   endtask

   task automatic test_alu_single;
      set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      n_tests++; if (wb.src_ready !== 3'b001) begin n_fail++; $display("FAIL alu_ready: got %b expected 001", wb.src_ready); end
      tick();
      wb.src_valid = 3'b000;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b expected 1", wb.gpr_we); end
      n_tests++; if (wb.gpr_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", wb.gpr_rd); end
      n_tests++; if (wb.gpr_di !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_di: got %h expected deadbeef", wb.gpr_di); end
      n_tests++; if (wb.busy !== 1'b1) begin n_fail++; $display("FAIL alu_busy: got %b expected 1", wb.busy); end
      tick();
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %b expected 0", wb.gpr_we); end
      n_tests++; if (wb.gpr_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd_hold: got %0d expected 5", wb.gpr_rd); end
      n_tests++; if (wb.gpr_di !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_di_hold: got %h expected deadbeef", wb.gpr_di); end
   endtask

   task automatic test_round_robin;
      logic [2:0]  exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      logic [31:0] exp_d [3] = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003};
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
      set_src(0, 1'b1, 5'd1, exp_d[0]);
      set_src(1, 1'b1, 5'd2, exp_d[1]);
      set_src(2, 1'b1, 5'd3, exp_d[2]);
      for (int c = 0; c < 6; c++) begin
         #1;
         n_tests++; if (wb.src_ready !== exp_g[c]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, wb.src_ready, exp_g[c]); end
         tick();
         n_tests++; if (wb.gpr_we !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d]: got %b expected 1", c, wb.gpr_we); end
         n_tests++; if (wb.gpr_rd !== 5'((c % 3) + 1)) begin n_fail++; $display("FAIL rr_rd[%0d]: got %0d expected %0d", c, wb.gpr_rd, (c % 3) + 1); end
         n_tests++; if (wb.gpr_di !== exp_d[c % 3]) begin n_fail++; $display("FAIL rr_di[%0d]: got %h expected %h", c, wb.gpr_di, exp_d[c % 3]); end
      end
      wb.src_valid = 3'b000;
      tick();
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL rr_we_end: got %b expected 0", wb.gpr_we); end
   endtask

   task automatic test_hazard;
      wb.gpr_ra    = 5'd7;
      wb.gpr_rb    = 5'd8;
      wb.iss_valid = 1'b1;
      wb.iss_rd    = 5'd7;
      #1;
      n_tests++; if (wb.hazard_a !== 1'b0) begin n_fail++; $display("FAIL hz_before_issue: got %b expected 0", wb.hazard_a); end
      tick();
      wb.iss_valid = 1'b0;
      #1;
      n_tests++; if (wb.hazard_a !== 1'b1) begin n_fail++; $display("FAIL hz_a_set: got %b expected 1", wb.hazard_a); end
      n_tests++; if (wb.hazard_b !== 1'b0) begin n_fail++; $display("FAIL hz_b_other: got %b expected 0", wb.hazard_b); end
      n_tests++; if (wb.busy !== 1'b1) begin n_fail++; $display("FAIL hz_busy: got %b expected 1", wb.busy); end
      tick();
      tick();
      n_tests++; if (wb.hazard_a !== 1'b1) begin n_fail++; $display("FAIL hz_a_held: got %b expected 1", wb.hazard_a); end
      set_src(1, 1'b1, 5'd7, 32'h12345678);
      #1;
      n_tests++; if (wb.src_ready !== 3'b010) begin n_fail++; $display("FAIL hz_mem_ready: got %b expected 010", wb.src_ready); end
      tick();
      wb.src_valid = 3'b000;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b1 || wb.gpr_rd !== 5'd7) begin n_fail++; $display("FAIL hz_mem_write: got we=%b rd=%0d expected we=1 rd=7", wb.gpr_we, wb.gpr_rd); end
      n_tests++; if (wb.hazard_a !== 1'b1) begin n_fail++; $display("FAIL hz_a_during_we: got %b expected 1", wb.hazard_a); end
      tick();
      n_tests++; if (wb.hazard_a !== 1'b0) begin n_fail++; $display("FAIL hz_a_cleared: got %b expected 0", wb.hazard_a); end
      n_tests++; if (wb.busy !== 1'b0) begin n_fail++; $display("FAIL hz_busy_clear: got %b expected 0", wb.busy); end

      // Re-issue to 7 on the edge where the older write to 7 lands.
      wb.iss_valid = 1'b1;
      wb.iss_rd    = 5'd7;
      tick();
      wb.iss_valid = 1'b0;
      set_src(1, 1'b1, 5'd7, 32'h5555AAAA);
      #1;
      n_tests++; if (wb.src_ready !== 3'b010) begin n_fail++; $display("FAIL hz2_ready: got %b expected 010", wb.src_ready); end
      tick();
      wb.src_valid = 3'b000;
      wb.iss_valid = 1'b1;
      wb.iss_rd    = 5'd7;
      wb.gpr_rb    = 5'd7;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b1 || wb.gpr_rd !== 5'd7) begin n_fail++; $display("FAIL hz2_write: got we=%b rd=%0d expected we=1 rd=7", wb.gpr_we, wb.gpr_rd); end
      tick();
      wb.iss_valid = 1'b0;
      #1;
      n_tests++; if (wb.hazard_a !== 1'b1) begin n_fail++; $display("FAIL hz2_set_wins_a: got %b expected 1", wb.hazard_a); end
      n_tests++; if (wb.hazard_b !== 1'b1) begin n_fail++; $display("FAIL hz2_set_wins_b: got %b expected 1", wb.hazard_b); end
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL hz2_we_drop: got %b expected 0", wb.gpr_we); end
      set_src(1, 1'b1, 5'd7, 32'h0);
      tick();
      wb.src_valid = 3'b000;
      tick();
      n_tests++; if (wb.hazard_a !== 1'b0 || wb.hazard_b !== 1'b0) begin n_fail++; $display("FAIL hz2_final_clear: got a=%b b=%b expected 0 0", wb.hazard_a, wb.hazard_b); end
   endtask

   task automatic test_x0;
      wb.gpr_ra    = 5'd0;
      wb.gpr_rb    = 5'd9;
      wb.iss_valid = 1'b1;
      wb.iss_rd    = 5'd9;
      tick();
      wb.iss_rd    = 5'd0;
      set_src(2, 1'b1, 5'd0, 32'hFFFFFFFF);
      #1;
      n_tests++; if (wb.src_ready !== 3'b100) begin n_fail++; $display("FAIL x0_ready: got %b expected 100", wb.src_ready); end
      n_tests++; if (wb.hazard_b !== 1'b1) begin n_fail++; $display("FAIL x0_pend9: got %b expected 1", wb.hazard_b); end
      tick();
      wb.iss_valid = 1'b0;
      wb.src_valid = 3'b000;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b expected 0", wb.gpr_we); end
      n_tests++; if (wb.hazard_a !== 1'b0) begin n_fail++; $display("FAIL x0_hazard_a: got %b expected 0", wb.hazard_a); end
      n_tests++; if (wb.hazard_b !== 1'b1) begin n_fail++; $display("FAIL x0_scoreboard: got %b expected 1", wb.hazard_b); end
      tick();
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL x0_we_late: got %b expected 0", wb.gpr_we); end
      n_tests++; if (wb.busy !== 1'b1) begin n_fail++; $display("FAIL x0_busy: got %b expected 1", wb.busy); end
      set_src(0, 1'b1, 5'd9, 32'h00000099);
      #1;
      n_tests++; if (wb.src_ready !== 3'b001) begin n_fail++; $display("FAIL x0_next_ready: got %b expected 001", wb.src_ready); end
      tick();
      wb.src_valid = 3'b000;
      tick();
      n_tests++; if (wb.hazard_b !== 1'b0 || wb.busy !== 1'b0) begin n_fail++; $display("FAIL x0_clear9: got hz=%b busy=%b expected 0 0", wb.hazard_b, wb.busy); end
   endtask

   task automatic test_hold_and_reset;
      wb.wb_hold = 1'b1;
      set_src(0, 1'b1, 5'd10, 32'h0A0A0A0A);
      set_src(1, 1'b1, 5'd11, 32'h0B0B0B0B);
      set_src(2, 1'b1, 5'd12, 32'h0C0C0C0C);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (wb.src_ready !== 3'b000) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b expected 000", c, wb.src_ready); end
         tick();
         n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d]: got %b expected 0", c, wb.gpr_we); end
      end
      wb.wb_hold = 1'b0;
      #1;
      n_tests++; if (wb.src_ready !== 3'b010) begin n_fail++; $display("FAIL hold_resume: got %b expected 010", wb.src_ready); end
      tick();
      wb.src_valid[1] = 1'b0;
      wb.iss_valid    = 1'b1;
      wb.iss_rd       = 5'd13;
      wb.gpr_ra       = 5'd13;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b1 || wb.gpr_rd !== 5'd11 || wb.gpr_di !== 32'h0B0B0B0B) begin n_fail++; $display("FAIL hold_write: got we=%b rd=%0d di=%h expected 1 11 0b0b0b0b", wb.gpr_we, wb.gpr_rd, wb.gpr_di); end
      n_tests++; if (wb.src_ready !== 3'b100) begin n_fail++; $display("FAIL pre_rst_ready: got %b expected 100", wb.src_ready); end
      tick();
      rst_n        = 1'b0;
      wb.src_valid = 3'b000;
      wb.iss_valid = 1'b0;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b expected 0", wb.gpr_we); end
      n_tests++; if (wb.hazard_a !== 1'b0 || wb.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_hz_busy: got hz=%b busy=%b expected 0 0", wb.hazard_a, wb.busy); end
      tick();
      rst_n = 1'b1;
      #1;
      n_tests++; if (wb.gpr_we !== 1'b0 || wb.gpr_rd !== 5'd0) begin n_fail++; $display("FAIL postrst_port: got we=%b rd=%0d expected 0 0", wb.gpr_we, wb.gpr_rd); end
      n_tests++; if (wb.hazard_a !== 1'b0 || wb.busy !== 1'b0) begin n_fail++; $display("FAIL postrst_pending: got hz=%b busy=%b expected 0 0", wb.hazard_a, wb.busy); end
      wb.src_valid = 3'b111;
      #1;
      n_tests++; if (wb.src_ready !== 3'b001) begin n_fail++; $display("FAIL postrst_ptr: got %b expected 001", wb.src_ready); end
      wb.src_valid = 3'b000;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_round_robin();
      test_hazard();
      test_x0();
      test_hold_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gpr_wb_sched.md
Name: gpr_wb_sched

Overview:
- Write-back scheduler for the register file, which has a single write port.
- Arbitrates three write-back sources (ALU, MEM load, CSR read data) round-robin and registers the winning write for one cycle onto the port.
- Keeps a 32-entry pending-write scoreboard so the decode stage can stall on read-after-write hazards for read ports a and b.

Parameters:
- NSRC, 3, number of write-back sources (fixed index order: 0 = ALU, 1 = MEM, 2 = CSR).
- XLEN, 32, data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- src_valid  input  NSRC  per-source write request.
- src_rd  input  5*NSRC  per-source destination register, source i at bits [5i+4:5i].
- src_data  input  XLEN*NSRC  per-source write data, source i at bits [XLEN*i+XLEN-1:XLEN*i].
- src_ready  output  NSRC  one-hot grant; transfer occurs when src_valid[i] and src_ready[i] are both high.
- wb_hold  input  1  suspends all grants (e.g. during register-file maintenance).
- iss_valid  input  1  an instruction with a destination register is issued.
- iss_rd  input  5  destination register of the issued instruction.
- gpr_ra  input  5  read address of port a (to hazard check).
- gpr_rb  input  5  read address of port b (to hazard check).
- hazard_a  output  1  gpr_ra has an outstanding write.
- hazard_b  output  1  gpr_rb has an outstanding write.
- gpr_we  output  1  register-file write enable.
- gpr_rd  output  5  register-file write address.
- gpr_di  output  XLEN  register-file write data.
- busy  output  1  any pending bit set or gpr_we high.

Behaviour:
- Reset (rst_n low at a rising edge):
  - gpr_we = 0, gpr_rd = 0, gpr_di = 0.
  - Pending vector cleared.
  - Round-robin pointer last = NSRC-1, so source 0 has first priority.
  - src_ready, hazard_a/b and busy evaluate to 0.
  - Reset mid-transfer discards the registered write; no gpr_we pulse follows.
- Arbitration is combinational and produces at most one grant per cycle:
  - Search starts at (last+1) mod NSRC and wraps.
  - The first i with src_valid[i] = 1 gets src_ready[i] = 1.
  - If wb_hold = 1 or no source is valid, src_ready = 0.
  - src_ready never asserts for an invalid source.
- Update on a grant:
  - last <= winner.
  - Next cycle (latency 1): gpr_we = 1 for exactly one cycle, gpr_rd = src_rd[winner], gpr_di = src_data[winner].
  - With no grant, gpr_we = 0 next cycle; gpr_rd and gpr_di hold their previous values.
- Register x0: a grant with rd = 0 completes the handshake but drives gpr_we = 0 and does not touch the scoreboard.
- Pending vector, 32 bits, bit 0 hardwired 0. Per edge:
  - Set pending[iss_rd] when iss_valid and iss_rd != 0.
  - Clear pending[gpr_rd] when gpr_we is high in the current cycle (the write lands this edge).
  - If set and clear hit the same register on one edge, set wins (newer producer).
- Hazard outputs:
  - hazard_a = pending[gpr_ra], hazard_b = pending[gpr_rb], combinational; 0 for address 0.
  - No bypass: a register reads non-hazard on the cycle after its gpr_we pulse.
- Sources hold src_valid/rd/data until granted. The block tolerates valid dropping without a grant; no state is kept for that source.
- Starvation bound: with wb_hold low, a continuously valid source is granted within NSRC cycles.
- A write-back to a register with no pending bit is legal; it writes and the clear is a no-op.

Test Plan:
- Reset, then release; idle -> gpr_we = 0, src_ready = 000, hazard_a/b = 0, busy = 0.
- ALU alone valid, rd = 5, data = 0xDEADBEEF -> src_ready = 001 that cycle; next cycle gpr_we = 1, gpr_rd = 5, gpr_di = 0xDEADBEEF; following cycle gpr_we = 0.
- All three sources held valid for 6 cycles -> grants 001, 010, 100, 001, 010, 100; each gpr_we pulse carries the matching rd and data.
- Issue rd = 7; check gpr_ra = 7 -> hazard_a = 1 until MEM write-back to 7 pulses gpr_we; hazard_a = 0 the next cycle. Then issue rd = 7 on the same edge as a write-back to 7 -> pending[7] stays 1.
- CSR valid with rd = 0 -> src_ready[2] = 1, gpr_we stays 0, scoreboard unchanged; gpr_ra = 0 -> hazard_a = 0 always.
- wb_hold = 1 with all sources valid for 3 cycles -> src_ready = 000, no gpr_we; release hold -> grant resumes at (last+1). Assert rst_n = 0 on the cycle after a grant -> no gpr_we pulse, pending cleared.
